noc_port_adapter: RTL and testbench

Parametrised NoC port adapter between the Nios II PIO-style interface and one NoC router port, generalising the fixed 32-bit data / 8-bit address / single-interrupt PIO connection. It buffers outgoing {destination, data} words in a TX FIFO and incoming words in an RX FIFO, with valid/ready handshakes on the NoC side. It raises a configurable processor interrupt on receive, and keeps sticky overflow flags for dropped writes.

---
 rtl/noc_port_adapter_if.sv | 47 ++++
 rtl/noc_port_adapter.sv | 134 +++++++++++++
 tb/tb_noc_port_adapter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_port_adapter_if.sv
// CPU-side PIO signals and NoC router-port handshake signals of one adapter.
// The adapter binds the slave modport; the CPU/router side uses master.
interface noc_port_adapter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W-1:0] tx_addr;
    logic              tx_write;
    logic              tx_full;
    logic [CNT_W-1:0]  tx_count;
    logic [DATA_W-1:0] rx_data;
    logic              rx_read;
    logic              rx_empty;
    logic [CNT_W-1:0]  rx_count;
    logic              irq_en;
    logic              irq;
    logic              err_clr;
    logic              tx_overflow;
    logic              rx_underflow;
    logic [DATA_W-1:0] noc_out_data;
    logic [ADDR_W-1:0] noc_out_addr;
    logic              noc_out_valid;
    logic              noc_out_ready;
    logic [DATA_W-1:0] noc_in_data;
    logic              noc_in_valid;
    logic              noc_in_ready;

    modport slave (
        input  tx_data, tx_addr, tx_write, rx_read, irq_en, err_clr,
               noc_out_ready, noc_in_data, noc_in_valid,
        output tx_full, tx_count, rx_data, rx_empty, rx_count, irq,
               tx_overflow, rx_underflow, noc_out_data, noc_out_addr,
               noc_out_valid, noc_in_ready
    );

    modport master (
        output tx_data, tx_addr, tx_write, rx_read, irq_en, err_clr,
               noc_out_ready, noc_in_data, noc_in_valid,
        input  tx_full, tx_count, rx_data, rx_empty, rx_count, irq,
               tx_overflow, rx_underflow, noc_out_data, noc_out_addr,
               noc_out_valid, noc_in_ready
    );
endinterface

// File: rtl/noc_port_adapter.sv
// NoC port adapter: TX FIFO of {addr, data} towards the router, RX FIFO from it,
// receive interrupt (level or pulse) and sticky overflow/underflow flags.
module noc_port_adapter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 4,
    parameter int IRQ_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    noc_port_adapter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TXW   = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return cnt + CNT_W'(1);
            2'b01:   return cnt - CNT_W'(1);
            default: return cnt;
        endcase
    endfunction

    // DEPTH is a power of two, so plain overflow of the pointer is the wrap.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr,
                                                  input logic adv);
        return adv ? ptr + PTR_W'(1) : ptr;
    endfunction

    function automatic logic sticky_next(input logic q, input logic set, input logic clr);
        if (set)
            return 1'b1;
        else if (clr)
            return 1'b0;
        else
            return q;
    endfunction

    logic [TXW-1:0]    tx_mem_q [DEPTH];
    logic [PTR_W-1:0]  tx_wptr_q, tx_wptr_d;
    logic [PTR_W-1:0]  tx_rptr_q, tx_rptr_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              tx_full, tx_push, tx_pop;

    logic [DATA_W-1:0] rx_mem_q [DEPTH];
    logic [PTR_W-1:0]  rx_wptr_q, rx_wptr_d;
    logic [PTR_W-1:0]  rx_rptr_q, rx_rptr_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              rx_udf_q, rx_udf_d;
    logic              rx_full, rx_empty, rx_push, rx_pop;

    logic              irq_q, irq_d;

    // Full/empty come from registered counts only, so a push while full is
    // dropped even when the other side pops in the same cycle.
    always_comb begin
        tx_full   = (tx_cnt_q == FULL_CNT);
        tx_push   = bus.tx_write && !tx_full;
        tx_pop    = (tx_cnt_q != '0) && bus.noc_out_ready;
        tx_wptr_d = ptr_next(tx_wptr_q, tx_push);
        tx_rptr_d = ptr_next(tx_rptr_q, tx_pop);
        tx_cnt_d  = cnt_next(tx_cnt_q, tx_push, tx_pop);
        tx_ovf_d  = sticky_next(tx_ovf_q, bus.tx_write && tx_full, bus.err_clr);
    end

    always_comb begin
        rx_full   = (rx_cnt_q == FULL_CNT);
        rx_empty  = (rx_cnt_q == '0);
        rx_push   = bus.noc_in_valid && !rx_full;
        rx_pop    = bus.rx_read && !rx_empty;
        rx_wptr_d = ptr_next(rx_wptr_q, rx_push);
        rx_rptr_d = ptr_next(rx_rptr_q, rx_pop);
        rx_cnt_d  = cnt_next(rx_cnt_q, rx_push, rx_pop);
        rx_udf_d  = sticky_next(rx_udf_q, bus.rx_read && rx_empty, bus.err_clr);
    end

    always_comb begin
        if (IRQ_MODE == 0)
            irq_d = bus.irq_en && (rx_cnt_d != '0);
        else
            irq_d = bus.irq_en && rx_push;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            rx_udf_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_udf_q  <= rx_udf_d;
            irq_q     <= irq_d;
        end
    end

    // Storage is deliberately unreset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem_q[tx_wptr_q] <= {bus.tx_addr, bus.tx_data};
        if (rx_push)
            rx_mem_q[rx_wptr_q] <= bus.noc_in_data;
    end

    assign bus.tx_full       = tx_full;
    assign bus.tx_count      = tx_cnt_q;
    assign bus.tx_overflow   = tx_ovf_q;
    assign bus.noc_out_valid = (tx_cnt_q != '0);
    assign bus.noc_out_addr  = tx_mem_q[tx_rptr_q][TXW-1:DATA_W];
    assign bus.noc_out_data  = tx_mem_q[tx_rptr_q][DATA_W-1:0];

    assign bus.rx_data       = rx_mem_q[rx_rptr_q];
    assign bus.rx_empty      = rx_empty;
    assign bus.rx_count      = rx_cnt_q;
    assign bus.rx_underflow  = rx_udf_q;
    assign bus.noc_in_ready  = !rx_full;

    assign bus.irq           = irq_q;
endmodule

// File: tb/tb_noc_port_adapter.sv
// Scoreboard bench for noc_port_adapter: level-IRQ instance for datapath and
// flags, pulse-IRQ instance for the interrupt mode.
module tb_noc_port_adapter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    noc_port_adapter_if #(.DATA_W(32), .ADDR_W(8), .DEPTH(4)) b0 ();
    noc_port_adapter_if #(.DATA_W(32), .ADDR_W(8), .DEPTH(4)) b1 ();

    noc_port_adapter #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .IRQ_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0));
    noc_port_adapter #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .IRQ_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1));

    int errors = 0;
    int checks = 0;
    logic [39:0] tx_exp[$];
    logic [31:0] rx_exp[$];

    int   txs, rxs, maxtx, maxrx;
    logic rx_pend, acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer is decided by signals stable at the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (b0.noc_out_valid && b0.noc_out_ready) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL noc_out_unexpected: got 0x%0h expected no transfer",
                             {b0.noc_out_addr, b0.noc_out_data});
                end else begin
                    check("noc_out_word", {b0.noc_out_addr, b0.noc_out_data}, tx_exp.pop_front());
                end
            end
            if (b0.rx_read && !b0.rx_empty) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no word", b0.rx_data);
                end else begin
                    check("rx_word", b0.rx_data, rx_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.tx_data = '0; b0.tx_addr = '0; b0.tx_write = 0; b0.rx_read = 0;
        b0.irq_en = 0; b0.err_clr = 0; b0.noc_out_ready = 0;
        b0.noc_in_data = '0; b0.noc_in_valid = 0;
        b1.tx_data = '0; b1.tx_addr = '0; b1.tx_write = 0; b1.rx_read = 0;
        b1.irq_en = 0; b1.err_clr = 0; b1.noc_out_ready = 0;
        b1.noc_in_data = '0; b1.noc_in_valid = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_rx_empty", b0.rx_empty, 1);
        check("rst_noc_in_ready", b0.noc_in_ready, 1);
        check("rst_noc_out_valid", b0.noc_out_valid, 0);
        check("rst_irq", b0.irq, 0);
        check("rst_tx_count", b0.tx_count, 0);
        check("rst_rx_count", b0.rx_count, 0);
        check("rst_tx_full", b0.tx_full, 0);
        check("rst_flags", {b0.tx_overflow, b0.rx_underflow}, 0);
        check("rst_irq_pulse_dut", b1.irq, 0);

        // TX burst with router stalled
        b0.noc_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            b0.tx_write = 1;
            b0.tx_addr  = 8'h11 + 8'(i);
            b0.tx_data  = 32'hA000_0001 + 32'(i);
            tx_exp.push_back({b0.tx_addr, b0.tx_data});
            tick();
            if (i == 0) begin
                check("tx_lat_valid", b0.noc_out_valid, 1);
                check("tx_lat_head", {b0.noc_out_addr, b0.noc_out_data}, 40'h11_A000_0001);
            end
        end
        check("tx_full_at_4", b0.tx_full, 1);
        check("tx_count_4", b0.tx_count, 4);
        check("tx_ovf_before", b0.tx_overflow, 0);
        b0.tx_addr = 8'h15;
        b0.tx_data = 32'hA000_0005;
        tick();
        b0.tx_write = 0;
        check("tx_ovf_set", b0.tx_overflow, 1);
        check("tx_count_after_drop", b0.tx_count, 4);
        b0.noc_out_ready = 1;
        repeat (4) tick();
        check("tx_drain_valid", b0.noc_out_valid, 0);
        check("tx_drain_count", b0.tx_count, 0);
        check("tx_drain_scoreboard", tx_exp.size(), 0);
        check("tx_ovf_sticky", b0.tx_overflow, 1);
        b0.err_clr = 1;
        tick();
        b0.err_clr = 0;
        check("tx_ovf_clr", b0.tx_overflow, 0);

        // RX fill, no reads
        for (int i = 0; i < 4; i++) begin
            b0.noc_in_valid = 1;
            b0.noc_in_data  = 32'hB1 + 32'(i);
            rx_exp.push_back(b0.noc_in_data);
            tick();
            if (i == 0) check("rx_lat_nonempty", b0.rx_empty, 0);
        end
        check("rx_full_ready", b0.noc_in_ready, 0);
        check("rx_count_4", b0.rx_count, 4);
        check("rx_irq_disabled", b0.irq, 0);
        b0.noc_in_data = 32'hB5;
        tick();
        tick();
        check("rx_held_count", b0.rx_count, 4);
        b0.noc_in_valid = 0;
        b0.rx_read = 1;
        repeat (4) tick();
        check("rx_drain_empty", b0.rx_empty, 1);
        check("rx_udf_before", b0.rx_underflow, 0);
        tick();
        b0.rx_read = 0;
        check("rx_udf_set", b0.rx_underflow, 1);
        check("rx_udf_count", b0.rx_count, 0);
        b0.rx_read = 1;
        b0.err_clr = 1;
        tick();
        b0.rx_read = 0;
        check("rx_udf_set_wins", b0.rx_underflow, 1);
        tick();
        b0.err_clr = 0;
        check("rx_udf_clr", b0.rx_underflow, 0);

        // Level IRQ
        b0.irq_en = 1;
        b0.noc_in_valid = 1;
        b0.noc_in_data = 32'hC1;
        rx_exp.push_back(32'hC1);
        tick();
        b0.noc_in_valid = 0;
        check("irq0_rise", b0.irq, 1);
        tick();
        check("irq0_hold", b0.irq, 1);
        b0.rx_read = 1;
        tick();
        b0.rx_read = 0;
        check("irq0_fall", b0.irq, 0);
        b0.noc_in_valid = 1;
        b0.noc_in_data = 32'hC2;
        rx_exp.push_back(32'hC2);
        b0.irq_en = 0;
        tick();
        b0.noc_in_valid = 0;
        check("irq0_disabled", b0.irq, 0);
        check("irq0_disabled_count", b0.rx_count, 1);
        b0.rx_read = 1;
        tick();
        b0.rx_read = 0;

        // Pulse IRQ
        b1.irq_en = 1;
        for (int i = 0; i < 3; i++) begin
            b1.noc_in_valid = 1;
            b1.noc_in_data = 32'hD1 + 32'(i);
            tick();
            check("irq1_pulse", b1.irq, 1);
        end
        b1.noc_in_valid = 0;
        tick();
        check("irq1_pulse_end", b1.irq, 0);
        b1.irq_en = 0;
        b1.noc_in_valid = 1;
        b1.noc_in_data = 32'hD4;
        tick();
        b1.noc_in_valid = 0;
        check("irq1_disabled", b1.irq, 0);
        check("irq1_rx_count", b1.rx_count, 4);

        // Stream 3*DEPTH words each way with random stalls
        txs = 0; rxs = 0; maxtx = 0; maxrx = 0; rx_pend = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (txs == 12 && rxs == 12 && !rx_pend && tx_exp.size() == 0 && rx_exp.size() == 0)
                break;
            if (txs < 12 && !b0.tx_full && $urandom_range(0, 3) != 0) begin
                b0.tx_write = 1;
                b0.tx_addr  = 8'h40 + 8'(txs);
                b0.tx_data  = 32'hD000_0000 + 32'(txs);
                tx_exp.push_back({b0.tx_addr, b0.tx_data});
                txs++;
            end else begin
                b0.tx_write = 0;
            end
            b0.noc_out_ready = ($urandom_range(0, 2) != 0);
            if (!rx_pend && rxs < 12 && $urandom_range(0, 3) != 0) begin
                rx_pend = 1;
                b0.noc_in_data = 32'hE000_0000 + 32'(rxs);
                rx_exp.push_back(b0.noc_in_data);
                rxs++;
            end
            b0.noc_in_valid = rx_pend;
            b0.rx_read = !b0.rx_empty && ($urandom_range(0, 2) != 0);
            acc = b0.noc_in_valid && b0.noc_in_ready;
            tick();
            if (acc) rx_pend = 0;
            if (int'(b0.tx_count) > maxtx) maxtx = int'(b0.tx_count);
            if (int'(b0.rx_count) > maxrx) maxrx = int'(b0.rx_count);
        end
        b0.tx_write = 0; b0.noc_in_valid = 0; b0.rx_read = 0; b0.noc_out_ready = 0;
        check("stream_tx_issued", txs, 12);
        check("stream_rx_issued", rxs, 12);
        check("stream_tx_drained", tx_exp.size(), 0);
        check("stream_rx_drained", rx_exp.size(), 0);
        check("stream_tx_max_le_depth", maxtx <= 4, 1);
        check("stream_rx_max_le_depth", maxrx <= 4, 1);
        check("stream_no_flags", {b0.tx_overflow, b0.rx_underflow}, 0);

        // Asynchronous reset with two words in each FIFO
        b0.irq_en = 1;
        for (int i = 0; i < 2; i++) begin
            b0.tx_write = 1;
            b0.tx_addr = 8'h70 + 8'(i);
            b0.tx_data = 32'hF0 + 32'(i);
            b0.noc_in_valid = 1;
            b0.noc_in_data = 32'hF8 + 32'(i);
            tick();
        end
        b0.tx_write = 0;
        b0.noc_in_valid = 0;
        check("prerst_tx_count", b0.tx_count, 2);
        check("prerst_rx_count", b0.rx_count, 2);
        check("prerst_irq", b0.irq, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tx_count", b0.tx_count, 0);
        check("arst_rx_count", b0.rx_count, 0);
        check("arst_noc_out_valid", b0.noc_out_valid, 0);
        check("arst_rx_empty", b0.rx_empty, 1);
        check("arst_noc_in_ready", b0.noc_in_ready, 1);
        check("arst_irq", b0.irq, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        b0.noc_out_ready = 1;
        tick();
        tick();
        check("postrst_noc_out_valid", b0.noc_out_valid, 0);
        check("postrst_rx_empty", b0.rx_empty, 1);
        check("postrst_irq", b0.irq, 0);

        check("final_tx_scoreboard", tx_exp.size(), 0);
        check("final_rx_scoreboard", rx_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
